// File: rtl/mnist_pixel_packer.sv
// Packs a per-image stream of pixels into FIFO words, zero-padding a partial final word.
// Enforces image framing, flags length errors (sticky) and counts completed images.
module mnist_pixel_packer #(
   parameter int unsigned PIX_WIDTH    = 8,
   parameter int unsigned PIX_PER_WORD = 4,
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned IMG_PIXELS   = 784
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   input  logic [PIX_WIDTH-1:0] in_data,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic                 push,
   output logic [WIDTH-1:0]     wdata,
   input  logic                 full,
   output logic                 img_done,
   output logic [15:0]          img_count,
   output logic                 len_err
);

   localparam int unsigned LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
   localparam int unsigned CNT_W  = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);
   localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(IMG_PIXELS - 1);

   typedef enum logic [0:0] {StFill, StDrain} state_t;

   state_t             state_q;
   logic [LANE_W-1:0]  lane_q;
   logic [CNT_W-1:0]   pix_cnt_q;
   logic [WIDTH-1:0]   asm_q;
   logic [WIDTH-1:0]   out_q;
   logic               out_vld_q;
   logic               out_is_last_q;
   logic               img_done_q;
   logic [15:0]        img_count_q;
   logic               len_err_q;

   logic               accept;
   logic               at_last_pix;
   logic               end_img;
   logic               close;
   logic [WIDTH-1:0]   merged;

   // A pending word only blocks input when the FIFO cannot take it this cycle.
   assign in_ready    = (state_q == StFill) && (!out_vld_q || !full);
   assign push        = out_vld_q && !full;
   assign wdata       = out_q;
   assign img_done    = img_done_q;
   assign img_count   = img_count_q;
   assign len_err     = len_err_q;

   assign accept      = in_valid && in_ready;
   assign at_last_pix = (pix_cnt_q == LAST_PIX);
   assign end_img     = in_last || at_last_pix;
   assign close       = accept && ((lane_q == LAST_LANE) || end_img);

   // Lanes above the current one are still zero in asm_q, which gives the zero padding.
   always_comb begin
      merged = asm_q;
      for (int unsigned k = 0; k < PIX_PER_WORD; k++) begin
         if (lane_q == LANE_W'(k)) begin
            merged[k*PIX_WIDTH +: PIX_WIDTH] = in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StFill;
         lane_q        <= '0;
         pix_cnt_q     <= '0;
         asm_q         <= '0;
         out_q         <= '0;
         out_vld_q     <= 1'b0;
         out_is_last_q <= 1'b0;
         img_done_q    <= 1'b0;
         img_count_q   <= '0;
         len_err_q     <= 1'b0;
      end else begin
         img_done_q <= 1'b0;

         if (push && out_is_last_q) begin
            out_is_last_q <= 1'b0;
            state_q       <= StFill;
            img_done_q    <= 1'b1;
            img_count_q   <= img_count_q + 1'b1;
         end

         if (close) begin
            out_vld_q <= 1'b1;
         end else if (push) begin
            out_vld_q <= 1'b0;
         end

         if (accept) begin
            if (close) begin
               out_q  <= merged;
               asm_q  <= '0;
               lane_q <= '0;
            end else begin
               asm_q  <= merged;
               lane_q <= lane_q + 1'b1;
            end

            if (end_img) begin
               pix_cnt_q     <= '0;
               out_is_last_q <= 1'b1;
               state_q       <= StDrain;
            end else begin
               pix_cnt_q <= pix_cnt_q + 1'b1;
            end

            // Early last or missing last: the image still ends here.
            if (in_last != at_last_pix) begin
               len_err_q <= 1'b1;
            end
         end
      end
   end

endmodule
